// File: rtl/pr_read_arbiter.sv
// AXI read-address arbiter for the PageRank engine: round-robin AR sharing with per-ID credits and R steering by rid_m.
// Optional macro PR_RD_ARB_PRIO_EN gives requester N_REQ-1 strict priority over the round-robin group.
module pr_read_arbiter #(
    parameter int N_REQ     = 3,
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*64-1:0]      req_addr,
    input  logic [N_REQ*8-1:0]       req_len,
    output logic [N_REQ-1:0]         req_ready,
    output logic [15:0]              arid_m,
    output logic [63:0]              araddr_m,
    output logic [7:0]               arlen_m,
    output logic [2:0]               arsize_m,
    output logic                     arvalid_m,
    input  logic                     arready_m,
    input  logic [15:0]              rid_m,
    input  logic [511:0]             rdata_m,
    input  logic [1:0]               rresp_m,
    input  logic                     rlast_m,
    input  logic                     rvalid_m,
    output logic                     rready_m,
    output logic [N_REQ-1:0]         resp_valid,
    input  logic [N_REQ-1:0]         resp_ready,
    output logic [511:0]             resp_data,
    output logic                     resp_last,
    output logic                     resp_err,
    output logic [N_REQ*CNT_W-1:0]   outst_cnt,
    output logic                     err_bad_id,
    output logic                     idle
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
`ifdef PR_RD_ARB_PRIO_EN
    localparam int RR_N = (N_REQ > 1) ? N_REQ - 1 : 1;
`endif

    typedef enum logic {S_ARB, S_ISSUE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [PTR_W-1:0]   w_win;
    logic               w_found;
    logic               w_grant;
    logic [N_REQ-1:0]   w_elig;
    logic [CNT_W-1:0]   r_cnt [N_REQ];
    logic [15:0]        r_arid;
    logic [63:0]        r_araddr;
    logic [7:0]         r_arlen;
    logic               r_arvalid;
    logic               r_err;
    logic               r_idle;
    logic               w_ar_hs;
    logic               w_rid_ok;
    logic               w_last_hs;
    logic [N_REQ-1:0]   w_inc;
    logic [N_REQ-1:0]   w_dec;
    logic               w_zero_dec;
    logic               w_all_zero;

    // Simultaneous issue and retire on one ID cancel out; a retire on an empty counter holds at zero.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
        if (inc && !dec)
            return cnt + 1'b1;
        if (dec && !inc && (cnt != '0))
            return cnt - 1'b1;
        return cnt;
    endfunction

    for (genvar i = 0; i < N_REQ; i++) begin : g_req
        assign w_elig[i]     = req_valid[i] && (r_cnt[i] < CNT_W'(MAX_OUTST));
        assign w_inc[i]      = w_ar_hs && (r_arid == 16'(i));
        assign w_dec[i]      = w_last_hs && (rid_m == 16'(i));
        assign resp_valid[i] = rvalid_m && (rid_m == 16'(i));
        assign outst_cnt[CNT_W*i +: CNT_W] = r_cnt[i];
    end

    always_comb begin
        w_found   = 1'b0;
        w_win     = '0;
        w_ptr_nxt = r_ptr;
`ifdef PR_RD_ARB_PRIO_EN
        if (w_elig[N_REQ-1]) begin
            w_found = 1'b1;
            w_win   = PTR_W'(N_REQ - 1);
        end else begin
            for (int k = 0; k < RR_N; k++) begin
                if (!w_found && w_elig[(int'(r_ptr) + k) % RR_N]) begin
                    w_found = 1'b1;
                    w_win   = PTR_W'((int'(r_ptr) + k) % RR_N);
                end
            end
            if (w_found)
                w_ptr_nxt = PTR_W'((int'(w_win) + 1) % RR_N);
        end
`else
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && w_elig[(int'(r_ptr) + k) % N_REQ]) begin
                w_found = 1'b1;
                w_win   = PTR_W'((int'(r_ptr) + k) % N_REQ);
            end
        end
        if (w_found)
            w_ptr_nxt = PTR_W'((int'(w_win) + 1) % N_REQ);
`endif
    end

    assign w_grant = w_found && (r_state == S_ARB) && !rst;
    assign w_ar_hs = r_arvalid && arready_m;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ARB:   if (w_grant) w_state_nxt = S_ISSUE;
            S_ISSUE: if (w_ar_hs) w_state_nxt = S_ARB;
            default: w_state_nxt = S_ARB;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (w_grant)
            req_ready[w_win] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_ARB;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arvalid <= 1'b0;
        end else if (w_grant) begin
            r_ptr     <= w_ptr_nxt;
            r_arid    <= 16'(w_win);
            r_araddr  <= req_addr[64*int'(w_win) +: 64];
            r_arlen   <= req_len[8*int'(w_win) +: 8];
            r_arvalid <= 1'b1;
        end else if (w_ar_hs) begin
            r_arvalid <= 1'b0;
        end
    end

    // Beats with an unknown ID are always accepted so a stray ID cannot stall the R channel.
    assign w_rid_ok  = rid_m < 16'(N_REQ);
    assign rready_m  = w_rid_ok ? resp_ready[rid_m[PTR_W-1:0]] : 1'b1;
    assign w_last_hs = rvalid_m && rready_m && rlast_m && w_rid_ok;

    always_comb begin
        w_zero_dec = 1'b0;
        w_all_zero = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_dec[i] && !w_inc[i] && (r_cnt[i] == '0))
                w_zero_dec = 1'b1;
            if (r_cnt[i] != '0)
                w_all_zero = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (rst)
                r_cnt[i] <= '0;
            else
                r_cnt[i] <= cnt_next(r_cnt[i], w_inc[i], w_dec[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err  <= 1'b0;
            r_idle <= 1'b1;
        end else begin
            if ((rvalid_m && !w_rid_ok) || w_zero_dec)
                r_err <= 1'b1;
            r_idle <= !r_arvalid && w_all_zero;
        end
    end

    assign arid_m     = r_arid;
    assign araddr_m   = r_araddr;
    assign arlen_m    = r_arlen;
    assign arsize_m   = 3'b011;
    assign arvalid_m  = r_arvalid;
    assign resp_data  = rdata_m;
    assign resp_last  = rlast_m;
    assign resp_err   = |rresp_m;
    assign err_bad_id = r_err;
    assign idle       = r_idle;

endmodule

// File: tb/tb_pr_read_arbiter.sv
// Self-checking bench for pr_read_arbiter: cycle model of the arbiter rules plus directed literal checks.
module tb_pr_read_arbiter;

    localparam int N    = 3;
    localparam int MAXO = 4;
    localparam int CW   = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*64-1:0] req_addr;
    logic [N*8-1:0] req_len;
    logic [N-1:0]   req_ready;
    logic [15:0]    arid_m;
    logic [63:0]    araddr_m;
    logic [7:0]     arlen_m;
    logic [2:0]     arsize_m;
    logic           arvalid_m;
    logic           arready_m;
    logic [15:0]    rid_m;
    logic [511:0]   rdata_m;
    logic [1:0]     rresp_m;
    logic           rlast_m;
    logic           rvalid_m;
    logic           rready_m;
    logic [N-1:0]   resp_valid;
    logic [N-1:0]   resp_ready;
    logic [511:0]   resp_data;
    logic           resp_last;
    logic           resp_err;
    logic [N*CW-1:0] outst_cnt;
    logic           err_bad_id;
    logic           idle;

    pr_read_arbiter #(.N_REQ(N), .MAX_OUTST(MAXO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
        .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
        .arvalid_m(arvalid_m), .arready_m(arready_m),
        .rid_m(rid_m), .rdata_m(rdata_m), .rresp_m(rresp_m), .rlast_m(rlast_m),
        .rvalid_m(rvalid_m), .rready_m(rready_m),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_last(resp_last), .resp_err(resp_err),
        .outst_cnt(outst_cnt), .err_bad_id(err_bad_id), .idle(idle)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state: one pending AR at most, per-ID burst credits.
    bit          m_pend = 1'b0;
    int          m_id   = 0;
    logic [63:0] m_addr = '0;
    logic [7:0]  m_len  = '0;
    int          m_ptr  = 0;
    int          m_cnt [N] = '{0, 0, 0};
    bit          m_err  = 1'b0;
    bit          m_idle = 1'b1;

    function automatic int exp_grant();
        if (rst || m_pend) return -1;
`ifdef PR_RD_ARB_PRIO_EN
        if (req_valid[N-1] && m_cnt[N-1] < MAXO) return N-1;
        for (int k = 0; k < N-1; k++) begin
            int j;
            j = (m_ptr + k) % (N-1);
            if (req_valid[j] && m_cnt[j] < MAXO) return j;
        end
`else
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (req_valid[j] && m_cnt[j] < MAXO) return j;
        end
`endif
        return -1;
    endfunction

    always @(posedge clk) begin
        int  g;
        bit  all0;
        bit  last;
        bit  inc;
        bit  dec;
        if (rst) begin
            m_pend = 1'b0; m_id = 0; m_addr = '0; m_len = '0; m_ptr = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_err = 1'b0; m_idle = 1'b1;
        end else begin
            g = exp_grant();
            all0 = 1'b1;
            for (int i = 0; i < N; i++) if (m_cnt[i] != 0) all0 = 1'b0;
            m_idle = !m_pend && all0;
            last = rvalid_m && rlast_m && (int'(rid_m) < N) && resp_ready[rid_m[1:0]];
            for (int i = 0; i < N; i++) begin
                inc = m_pend && arready_m && (m_id == i);
                dec = last && (int'(rid_m) == i);
                if (inc && !dec) m_cnt[i]++;
                else if (dec && !inc) begin
                    if (m_cnt[i] == 0) m_err = 1'b1;
                    else m_cnt[i]--;
                end
            end
            if (rvalid_m && int'(rid_m) >= N) m_err = 1'b1;
            if (m_pend) begin
                if (arready_m) m_pend = 1'b0;
            end else if (g >= 0) begin
                m_pend = 1'b1;
                m_id   = g;
                m_addr = req_addr[64*g +: 64];
                m_len  = req_len[8*g +: 8];
`ifdef PR_RD_ARB_PRIO_EN
                if (g != N-1) m_ptr = (g + 1) % (N-1);
`else
                m_ptr = (g + 1) % N;
`endif
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            int          g;
            logic [N-1:0] e_rr;
            logic [N-1:0] e_rv;
            logic [N*CW-1:0] e_cnt;
            logic        e_rdy;
            @(negedge clk);
            g = exp_grant();
            e_rr = '0;
            if (g >= 0) e_rr[g] = 1'b1;
            for (int i = 0; i < N; i++) begin
                e_rv[i] = rvalid_m && (int'(rid_m) == i);
                e_cnt[CW*i +: CW] = CW'(m_cnt[i]);
            end
            e_rdy = (int'(rid_m) < N) ? resp_ready[rid_m[1:0]] : 1'b1;
            chk("req_ready",  512'(req_ready),  512'(e_rr));
            chk("arvalid_m",  512'(arvalid_m),  512'(m_pend));
            chk("arid_m",     512'(arid_m),     512'(m_id));
            chk("araddr_m",   512'(araddr_m),   512'(m_addr));
            chk("arlen_m",    512'(arlen_m),    512'(m_len));
            chk("arsize_m",   512'(arsize_m),   512'(3'b011));
            chk("resp_valid", 512'(resp_valid), 512'(e_rv));
            chk("rready_m",   512'(rready_m),   512'(e_rdy));
            chk("resp_data",  resp_data,        rdata_m);
            chk("resp_last",  512'(resp_last),  512'(rlast_m));
            chk("resp_err",   512'(resp_err),   512'(rresp_m != 2'b00));
            chk("outst_cnt",  512'(outst_cnt),  512'(e_cnt));
            chk("err_bad_id", 512'(err_bad_id), 512'(m_err));
            chk("idle",       512'(idle),       512'(m_idle));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] cnt_of(input int i);
        return outst_cnt[CW*i +: CW];
    endfunction

    int ids [$];
    int cyc [$];
`ifdef PR_RD_ARB_PRIO_EN
    int exp_ids [6] = '{2, 2, 2, 2, 0, 1};
    int c1_before = 1;
    int c0_before = 1;
`else
    int exp_ids [6] = '{0, 1, 2, 0, 1, 2};
    int c1_before = 2;
    int c0_before = 2;
`endif

    initial begin
        rst = 1'b1; req_valid = 3'b111;
        req_addr = {64'h3000, 64'h2000, 64'h1000};
        req_len  = {8'd3, 8'd1, 8'd0};
        arready_m = 1'b1; rvalid_m = 1'b0; rid_m = '0; rdata_m = '0;
        rresp_m = 2'b00; rlast_m = 1'b0; resp_ready = '0;
        step(); step();
        @(negedge clk);
        chk("rst_req_ready", 512'(req_ready), 512'(3'b000));
        chk("rst_arvalid",   512'(arvalid_m), 512'(1'b0));
        chk("rst_outst",     512'(outst_cnt), 512'(0));
        chk("rst_err",       512'(err_bad_id), 512'(1'b0));
        chk("rst_idle",      512'(idle),      512'(1'b1));

        // single request from requester 0
        step(); rst = 1'b0; req_valid = 3'b001;
        @(negedge clk); chk("t1_req_ready", 512'(req_ready), 512'(3'b001));
        step(); req_valid = 3'b000;
        @(negedge clk);
        chk("t1_arvalid", 512'(arvalid_m), 512'(1'b1));
        chk("t1_arid",    512'(arid_m),    512'(16'd0));
        chk("t1_araddr",  512'(araddr_m),  512'(64'h1000));
        step();
        @(negedge clk); chk("t1_cnt0", 512'(cnt_of(0)), 512'(3'd1));
        step(); rvalid_m = 1'b1; rid_m = 16'd0; rlast_m = 1'b1; resp_ready = 3'b111;
        rdata_m = {16{32'h0123_4567}};
        step(); rvalid_m = 1'b0;
        @(negedge clk); chk("t1_cnt0_ret", 512'(cnt_of(0)), 512'(3'd0));

        // all three requesters continuously valid
        step(); rst = 1'b1;
        step(); rst = 1'b0; req_valid = 3'b111;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (arvalid_m && arready_m) begin
                ids.push_back(int'(arid_m));
                cyc.push_back(k);
            end
            step();
        end
        req_valid = 3'b000;
        chk("t2_num_ar", 512'(ids.size()), 512'(6));
        for (int i = 0; i < 6; i++) begin
            if (i < ids.size()) chk("t2_ar_id", 512'(ids[i]), 512'(exp_ids[i]));
            if (i > 0 && i < cyc.size()) chk("t2_ar_gap", 512'(cyc[i] - cyc[i-1]), 512'(2));
        end

        // R back-pressure on ID 1, then acceptance
        rvalid_m = 1'b1; rid_m = 16'd1; rlast_m = 1'b1; resp_ready = 3'b000;
        rresp_m = 2'b10; rdata_m = {16{32'hDEAD_BEEF}};
        @(negedge clk);
        chk("t4_rready_hold", 512'(rready_m),   512'(1'b0));
        chk("t4_resp_valid",  512'(resp_valid), 512'(3'b010));
        step(); resp_ready = 3'b010;
        @(negedge clk);
        chk("t4_cnt1_held", 512'(cnt_of(1)), 512'(c1_before));
        chk("t4_rready",    512'(rready_m),  512'(1'b1));
        step(); rvalid_m = 1'b0; rresp_m = 2'b00;
        @(negedge clk); chk("t4_cnt1_dec", 512'(cnt_of(1)), 512'(c1_before - 1));

        // AR issue and last beat on ID 0 in the same cycle
        step(); req_valid = 3'b001;
        @(negedge clk); chk("t6_req_ready", 512'(req_ready), 512'(3'b001));
        step(); req_valid = 3'b000;
        rvalid_m = 1'b1; rid_m = 16'd0; rlast_m = 1'b1; resp_ready = 3'b001;
        @(negedge clk); chk("t6_ar_hs", 512'(arvalid_m && arready_m), 512'(1'b1));
        step(); rvalid_m = 1'b0;
        @(negedge clk); chk("t6_cnt0", 512'(cnt_of(0)), 512'(c0_before));

        // out-of-range ID
        step(); rvalid_m = 1'b1; rid_m = 16'd5; rlast_m = 1'b1; resp_ready = 3'b000;
        @(negedge clk);
        chk("t5_rready",     512'(rready_m),   512'(1'b1));
        chk("t5_resp_valid", 512'(resp_valid), 512'(3'b000));
        step(); rvalid_m = 1'b0;
        @(negedge clk); chk("t5_err", 512'(err_bad_id), 512'(1'b1));
        step(); step(); step();
        @(negedge clk); chk("t5_err_sticky", 512'(err_bad_id), 512'(1'b1));

        // reset while an AR is waiting for arready
        step(); arready_m = 1'b0; req_valid = 3'b001;
        @(negedge clk); chk("t7_req_ready", 512'(req_ready), 512'(3'b001));
        step(); req_valid = 3'b000;
        @(negedge clk); chk("t7_arvalid", 512'(arvalid_m), 512'(1'b1));
        step(); rst = 1'b1;
        step(); rst = 1'b0; arready_m = 1'b1;
        @(negedge clk);
        chk("t7_arvalid_drop", 512'(arvalid_m),  512'(1'b0));
        chk("t7_outst_clr",    512'(outst_cnt),  512'(0));
        chk("t7_err_clr",      512'(err_bad_id), 512'(1'b0));
        step(); rvalid_m = 1'b1; rid_m = 16'd0; rlast_m = 1'b1; resp_ready = 3'b001;
        @(negedge clk); chk("t7_rready", 512'(rready_m), 512'(1'b1));
        step(); rvalid_m = 1'b0;
        @(negedge clk); chk("t7_err_late", 512'(err_bad_id), 512'(1'b1));

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pr_read_arbiter.md
# pr_read_arbiter

Shares the single AXI read-address channel of the PageRank engine between its three read requesters: vertex stream (ID 0), in-edge stream (ID 1) and random PR reads (ID 2). It tags each AR with the requester index as `arid_m`, limits outstanding bursts per requester with credit counters, and steers returning R beats to the owning requester by `rid_m`. It replaces the per-state AR muxing inside the PageRank top level and sits between the PageRank read logic and the shell's `*_m` read ports.

## Interface
- `N_REQ`, 3: number of requesters; requester index = AXI ID.
- `MAX_OUTST`, 4: maximum outstanding bursts per requester.
- `CNT_W`, 3: width of each outstanding counter; must hold `MAX_OUTST`.
- `clk`  in  1  the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  N_REQ  per-requester read request.
- `req_addr`  in  N_REQ*64  per-requester byte address, 64-byte aligned; slice i = [64*i+63:64*i].
- `req_len`  in  N_REQ*8  per-requester AXI `arlen`.
- `req_ready`  out  N_REQ  one-cycle acceptance pulse, one-hot.
- `arid_m`, `araddr_m`, `arlen_m`, `arsize_m`, `arvalid_m`  out  16/64/8/3/1  AXI AR master.
- `arready_m`  in  1  AXI AR ready.
- `rid_m`, `rdata_m`, `rresp_m`, `rlast_m`, `rvalid_m`  in  16/512/2/1/1  AXI R channel.
- `rready_m`  out  1  AXI R ready.
- `resp_valid`  out  N_REQ  R beat for requester i.
- `resp_ready`  in  N_REQ  requester i accepts the beat.
- `resp_data`  out  512  `rdata_m`, shared by all requesters.
- `resp_last`  out  1  `rlast_m`.
- `resp_err`  out  1  `rresp_m != 0`.
- `outst_cnt`  out  N_REQ*CNT_W  live outstanding-burst counters.
- `err_bad_id`  out  1  sticky: a beat arrived with `rid_m >= N_REQ` or with a zero counter.
- `idle`  out  1  no AR pending and all counters zero.

## Operation
- FSM `S_ARB` → `S_ISSUE` → `S_ARB`.
- **S_ARB**: requester i is eligible when `req_valid[i]` is high and `outst_cnt[i] < MAX_OUTST`. The round-robin search starts at pointer `ptr`. On a win:
  - pulse `req_ready[winner]`;
  - latch `araddr_m`, `arlen_m` and `arid_m` = winner (zero-extended);
  - set `arvalid_m`, set `ptr` = (winner+1) mod `N_REQ`, go to S_ISSUE.
- **S_ISSUE**: hold all AR outputs stable until `arvalid_m & arready_m`. Then clear `arvalid_m`, increment `outst_cnt[arid_m]` and return to S_ARB.
- `arsize_m` is constant 3'b011.
- **R path**, combinational, zero latency:
  - `resp_valid[i] = rvalid_m & (rid_m == i)`.
  - `rready_m = resp_ready[rid_m]` for an in-range ID. For an out-of-range ID it is 1: the beat is dropped and `err_bad_id` is set.
- A handshaked beat with `rlast_m` decrements `outst_cnt[rid_m]`. The counter saturates at 0; decrementing a zero counter sets `err_bad_id`.
- Same-cycle AR handshake and last beat on the same ID: the counter is unchanged.
- No eligible requester: stay in S_ARB with `req_ready` = 0.

## Timing
- Reset values: state S_ARB, `ptr` 0, `arvalid_m` 0, `arid_m`/`araddr_m`/`arlen_m` 0, `req_ready` 0, all counters 0, `err_bad_id` 0, `idle` 1.
- Request accepted (`req_ready` pulse) in cycle T; `arvalid_m` is high from T+1.
- Peak throughput is one AR every 2 cycles with `arready_m` held high.
- `rst` mid-burst: `arvalid_m` drops the next cycle and counters clear. Beats arriving after reset are forwarded; their last beat sets `err_bad_id`.
- `idle` is registered and updates one cycle after the counters.

## Configuration
- `PR_RD_ARB_PRIO_EN` defined: requester `N_REQ-1` (PR reads) has strict priority whenever eligible. The remaining requesters round-robin among themselves, and `ptr` is only advanced by their grants.
- Undefined: pure round-robin across all requesters.

## Test plan
- Reset, then `req_valid`=3'b001, addr 0x1000, len 0, `arready_m`=1 → `req_ready[0]` pulse in cycle T; `arvalid_m`=1 with `arid_m`=0 and `araddr_m`=0x1000 in T+1; `outst_cnt[0]`=1 in T+2.
- All three requesters valid continuously, `arready_m`=1, macro undefined → AR IDs 0,1,2,0,1,2, one every 2 cycles.
- Same stimulus with `PR_RD_ARB_PRIO_EN` → IDs 2,2,2,2 until `outst_cnt[2]`=4, then 0,1 interleave.
- `rvalid_m`=1, `rid_m`=1, `rlast_m`=1, `resp_ready`=3'b000 → `rready_m`=0 and counter held. Then `resp_ready[1]`=1 → beat accepted and counter decrements by 1.
- `rid_m`=5 beat → `rready_m`=1 and `err_bad_id`=1, sticky until `rst`.
- AR handshake on ID 0 in the same cycle as the last beat for ID 0 with counter 2 → counter stays 2.
